reaction_arena: RTL
===================

REACTION_ARENA -- requirements
Module: reaction_arena

Interface
REQ-001 Parameter PLAYERS, default 4: number of player stop buttons (1..8).
REQ-002 Parameter TICK_DIV, default 50000: clk_50M cycles per 1 ms tick.
REQ-003 Parameter MIN_DELAY_MS, default 2000: minimum random delay in ms.
REQ-004 Parameter RANGE_LOG2, default 12: random delay span is 2^RANGE_LOG2 ms.
REQ-005 Parameter TIMEOUT_MS, default 9999: GO-phase timeout and result saturation value.
REQ-006 Parameter SEED, default 32'hACE1_2024: nonzero LFSR reset value.
REQ-007 Parameter TIME_W, default 14: width of each result field.
REQ-008 clk_50M  in  1  sole clock; all logic on the rising edge.
REQ-009 clear  in  1  synchronous, active-high reset.
REQ-010 start  in  1  round start request; acts on the rising edge.
REQ-011 stop  in  PLAYERS  per-player stop buttons; each acts on its rising edge.
REQ-012 LED  out  1  go indicator; high only in GO.
REQ-013 state  out  2  IDLE=0, WAIT=1, GO=2, DONE=3.
REQ-014 done  out  PLAYERS  player finished in this round (stopped, fouled or timed out).
REQ-015 foul  out  PLAYERS  player pressed stop during WAIT.
REQ-016 result_ms  out  PLAYERS*TIME_W  player i's reaction time in ms at bits [i*TIME_W +: TIME_W].
REQ-017 winner  out  max(1,clog2(PLAYERS))  index of the first valid stopper.
REQ-018 winner_valid  out  1  winner field holds a valid index.

Function
REQ-019 Inputs are already synchronous and debounced; the block SHALL register each previous value and detect a rising edge as in & ~prev.
REQ-020 A free-running 32-bit Galois LFSR (taps 32'h80200003) SHALL advance every cycle.
REQ-021 The ms divider SHALL clear to 0 on every entry to WAIT or GO; the tick fires on the cycle where divider == TICK_DIV-1.
REQ-022 In IDLE or DONE, a start edge SHALL enter WAIT with delay = MIN_DELAY_MS + lfsr[RANGE_LOG2-1:0] sampled that cycle; done, foul, result_ms, winner_valid and wait count SHALL clear, LED stays 0.
REQ-023 In WAIT and GO, start edges SHALL be ignored.
REQ-024 In WAIT, a stop edge on a not-done player i SHALL set foul[i]=1, done[i]=1 and result field i = 0 on the next cycle.
REQ-025 In WAIT, on the delay-th tick the block SHALL go to GO with LED=1 and elapsed=0; first GO cycle = first WAIT cycle + delay*TICK_DIV.
REQ-026 A stop edge in the same cycle as the delay-th tick SHALL count as a foul.
REQ-027 If all players are done in WAIT, the block SHALL go to DONE with LED=0 and winner_valid=0.
REQ-028 In GO, elapsed SHALL increment by 1 per tick.
REQ-029 In GO, a stop edge on a not-done player i SHALL set result field i = current elapsed (pre-increment) and done[i]=1.
REQ-030 The first GO stop SHALL set winner=i and winner_valid=1; for simultaneous edges the lowest index wins and all such players get the same result.
REQ-031 Stop edges from players already done SHALL be ignored.
REQ-032 When all players are done in GO, the next state SHALL be DONE with LED=0.
REQ-033 On the tick where elapsed would reach TIMEOUT_MS, every not-done player SHALL get result TIMEOUT_MS and done=1, and the state SHALL go to DONE with LED=0.
REQ-034 A stop edge coincident with the timeout tick SHALL take the pre-increment elapsed value.
REQ-035 In DONE, all outputs SHALL hold until clear or a start edge.

Reset
REQ-036 While clear=1: state=IDLE, LED=0, done=0, foul=0, result_ms=0, winner=0, winner_valid=0, divider/elapsed/wait count=0, lfsr=SEED.
REQ-037 While clear=1, the edge-detect registers SHALL load the current inputs, so a held button produces no edge after reset.
REQ-038 clear mid-round SHALL abort the round within one cycle, with no partial results retained.

Verification
Sim parameters: PLAYERS=4, TICK_DIV=10, MIN_DELAY_MS=20, RANGE_LOG2=4, TIMEOUT_MS=200.
REQ-039 Release clear, pulse start, capture lfsr[3:0]=r -> LED rises exactly (20+r)*10 cycles after WAIT entry.
REQ-040 Press stop[2] 5 cycles after WAIT entry -> foul=0100, done=0100, result2=0; other players unaffected; round continues to GO.
REQ-041 In GO, press stop[1] and stop[3] in the same cycle at elapsed=37, then stop[0] at 50 and stop[2] at 61 -> result1=result3=37, winner=1, winner_valid=1, result0=50, result2=61, DONE, LED=0.
REQ-042 No stops in GO -> after 200 ticks all results=200, done=1111, winner_valid=0, state=DONE.
REQ-043 All four players foul in WAIT -> DONE directly, LED never rises, foul=1111.
REQ-044 Assert clear during GO at elapsed=12 -> next cycle everything is at reset values; a stop held through clear produces no edge; a following start begins a fresh round.

Source files
------------

// File: rtl/reaction_arena.sv
// rtl/reaction_arena.sv - multi-player reaction timer: random delay, GO light, per-player ms results
module reaction_arena #(
   parameter int          PLAYERS      = 4,
   parameter int          TICK_DIV     = 50000,
   parameter int          MIN_DELAY_MS = 2000,
   parameter int          RANGE_LOG2   = 12,
   parameter int          TIMEOUT_MS   = 9999,
   parameter logic [31:0] SEED         = 32'hACE1_2024,
   parameter int          TIME_W       = 14,
   localparam int         WIN_W        = (PLAYERS > 1) ? $clog2(PLAYERS) : 1
) (
   input  logic                       clk_50M,
   input  logic                       clear,
   input  logic                       start,
   input  logic [PLAYERS-1:0]         stop,
   output logic                       LED,
   output logic [1:0]                 state,
   output logic [PLAYERS-1:0]         done,
   output logic [PLAYERS-1:0]         foul,
   output logic [PLAYERS*TIME_W-1:0]  result_ms,
   output logic [WIN_W-1:0]           winner,
   output logic                       winner_valid
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_GO   = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   state_t                      state_q, state_d;
   logic [31:0]                 lfsr_q;
   logic [31:0]                 div_q, div_d;
   logic [31:0]                 wait_q, wait_d;
   logic [31:0]                 delay_q, delay_d;
   logic [TIME_W-1:0]           elapsed_q, elapsed_d;
   logic                        start_prev;
   logic [PLAYERS-1:0]          stop_prev;
   logic [PLAYERS-1:0]          done_q, done_d;
   logic [PLAYERS-1:0]          foul_q, foul_d;
   logic [PLAYERS*TIME_W-1:0]   result_q, result_d;
   logic [WIN_W-1:0]            winner_q, winner_d;
   logic                        wv_q, wv_d;

   logic                        tick;
   logic                        start_edge;
   logic [PLAYERS-1:0]          hits;
   logic [WIN_W-1:0]            first;

   assign tick       = (div_q == 32'(TICK_DIV - 1));
   assign start_edge = start & ~start_prev;
   // Edges from players already finished this round never count.
   assign hits       = stop & ~stop_prev & ~done_q;

   always_comb begin
      state_d   = state_q;
      div_d     = tick ? 32'd0 : div_q + 32'd1;
      wait_d    = wait_q;
      delay_d   = delay_q;
      elapsed_d = elapsed_q;
      done_d    = done_q;
      foul_d    = foul_q;
      result_d  = result_q;
      winner_d  = winner_q;
      wv_d      = wv_q;
      first     = '0;
      for (int i = PLAYERS - 1; i >= 0; i--) begin
         if (hits[i]) first = WIN_W'(i);
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_edge) begin
               state_d   = S_WAIT;
               div_d     = 32'd0;
               wait_d    = 32'd0;
               elapsed_d = '0;
               delay_d   = 32'(MIN_DELAY_MS) + 32'(lfsr_q[RANGE_LOG2-1:0]);
               done_d    = '0;
               foul_d    = '0;
               result_d  = '0;
               winner_d  = '0;
               wv_d      = 1'b0;
            end
         end
         S_WAIT: begin
            done_d = done_q | hits;
            foul_d = foul_q | hits;
            for (int i = 0; i < PLAYERS; i++) begin
               if (hits[i]) result_d[i*TIME_W +: TIME_W] = '0;
            end
            if (tick) wait_d = wait_q + 32'd1;
            // A press on the final delay tick is still a foul, so fouls are folded in first.
            if (&done_d) begin
               state_d = S_DONE;
            end else if (tick && (wait_q == delay_q - 32'd1)) begin
               state_d   = S_GO;
               div_d     = 32'd0;
               elapsed_d = '0;
            end
         end
         S_GO: begin
            done_d = done_q | hits;
            for (int i = 0; i < PLAYERS; i++) begin
               if (hits[i]) result_d[i*TIME_W +: TIME_W] = elapsed_q;
            end
            if ((hits != '0) && !wv_q) begin
               winner_d = first;
               wv_d     = 1'b1;
            end
            if (tick) begin
               elapsed_d = elapsed_q + TIME_W'(1);
               if (elapsed_q == TIME_W'(TIMEOUT_MS - 1)) begin
                  for (int i = 0; i < PLAYERS; i++) begin
                     if (!done_d[i]) result_d[i*TIME_W +: TIME_W] = TIME_W'(TIMEOUT_MS);
                  end
                  done_d = '1;
               end
            end
            if (&done_d) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_50M) begin
      // Edge history follows the inputs even during clear so a held button stays quiet.
      start_prev <= start;
      stop_prev  <= stop;
      if (clear) begin
         state_q   <= S_IDLE;
         lfsr_q    <= SEED;
         div_q     <= 32'd0;
         wait_q    <= 32'd0;
         delay_q   <= 32'd0;
         elapsed_q <= '0;
         done_q    <= '0;
         foul_q    <= '0;
         result_q  <= '0;
         winner_q  <= '0;
         wv_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         lfsr_q    <= {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'd0);
         div_q     <= div_d;
         wait_q    <= wait_d;
         delay_q   <= delay_d;
         elapsed_q <= elapsed_d;
         done_q    <= done_d;
         foul_q    <= foul_d;
         result_q  <= result_d;
         winner_q  <= winner_d;
         wv_q      <= wv_d;
      end
   end

   assign LED          = (state_q == S_GO);
   assign state        = state_q;
   assign done         = done_q;
   assign foul         = foul_q;
   assign result_ms    = result_q;
   assign winner       = winner_q;
   assign winner_valid = wv_q;

endmodule
